// File: rtl/decodificador_7seg_bcd_pkg.sv
// ============================================================================
//  Module   : decodificador_7seg_bcd_pkg
//  Purpose  : Shared segment codes, blank/error BCD codes and filter FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package decodificador_7seg_bcd_pkg;

    // Segment codes, bits [6:0] = a..g, active-low (0 = lit)
    localparam logic [6:0] CERO    = 7'b0000001;
    localparam logic [6:0] UNO     = 7'b1001111;
    localparam logic [6:0] DOS     = 7'b0010010;
    localparam logic [6:0] TRES    = 7'b0000110;
    localparam logic [6:0] CUATRO  = 7'b1001100;
    localparam logic [6:0] CINCO   = 7'b0100100;
    localparam logic [6:0] SEIS    = 7'b0100000;
    localparam logic [6:0] SIETE   = 7'b0001111;
    localparam logic [6:0] OCHO    = 7'b0000000;
    localparam logic [6:0] NUEVE   = 7'b0000100;
    localparam logic [6:0] APAGADO = 7'b1111111;

    localparam logic [3:0] BCD_BLANCO = 4'hF;
    localparam logic [3:0] BCD_ERROR  = 4'hF;

    typedef enum logic [1:0] {
        ESPERA   = 2'd0,
        CUENTA   = 2'd1,
        RETENIDO = 2'd2
    } estado_t;

endpackage

`default_nettype wire

// File: rtl/decodificador_7seg_bcd_tabla.sv
// ============================================================================
//  Module   : tabla_7seg_bcd
//  Purpose  : Combinational lookup, 7-bit segment pattern -> {bcd, apagado, error}.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tabla_7seg_bcd
    import decodificador_7seg_bcd_pkg::*;
(
    input  logic [6:0] patron,
    output logic [3:0] bcd,
    output logic       apagado,
    output logic       error
);

    always_comb begin
        bcd     = BCD_ERROR;
        apagado = 1'b0;
        error   = 1'b0;
        case (patron)
            CERO:    bcd = 4'd0;
            UNO:     bcd = 4'd1;
            DOS:     bcd = 4'd2;
            TRES:    bcd = 4'd3;
            CUATRO:  bcd = 4'd4;
            CINCO:   bcd = 4'd5;
            SEIS:    bcd = 4'd6;
            SIETE:   bcd = 4'd7;
            OCHO:    bcd = 4'd8;
            NUEVE:   bcd = 4'd9;
            APAGADO: begin
                bcd     = BCD_BLANCO;
                apagado = 1'b1;
            end
            default: error = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/decodificador_7seg_bcd.sv
// ============================================================================
//  Module   : decodificador_7seg_bcd
//  Purpose  : Glitch-filtered readback of a multiplexed active-low 7-segment bus
//             into per-digit BCD registers. Optional: DECOD7SEG_PUNTO_EN (dp).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decodificador_7seg_bcd
    import decodificador_7seg_bcd_pkg::*;
#(
    parameter int N_DIGITOS = 4,
    parameter int ESTABLE   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_DIGITOS-1:0]   anodo,
    input  logic [7:0]             segmentos,
    output logic [4*N_DIGITOS-1:0] bcd,
    output logic [N_DIGITOS-1:0]   apagado,
    output logic [N_DIGITOS-1:0]   error,
    output logic [N_DIGITOS-1:0]   punto,
    output logic                   nuevo,
    output logic                   barrido
);

    localparam int             c_cw       = $clog2(ESTABLE + 1);
    localparam int             c_kw       = N_DIGITOS + 8;
    localparam logic [c_cw-1:0] c_cnt_uno = c_cw'(1);
    localparam logic [c_cw-1:0] c_cnt_max = c_cw'(ESTABLE);

    logic [c_kw-1:0]      r_sync;
    logic [c_kw-1:0]      r_muestra;
    logic [c_kw-1:0]      r_previa;
    estado_t              r_estado;
    logic [c_cw-1:0]      r_cnt;
    logic [N_DIGITOS-1:0] r_mascara;

    logic [N_DIGITOS-1:0] w_an;
    logic [c_kw-1:0]      w_clave;
    logic                 w_valida;
    logic                 w_igual;
    logic                 w_reinicio;
    logic                 w_commit;
    logic [c_cw-1:0]      w_cnt_inc;
    logic [N_DIGITOS-1:0] w_sel;
    logic [N_DIGITOS-1:0] w_mascara_sig;
    logic                 w_completo;
    logic                 w_cambio;
    logic [3:0]           w_dec_bcd;
    logic                 w_dec_ap;
    logic                 w_dec_er;
    logic                 w_punto;

    // Two-flop synchronizer; idles at all-ones so reset looks like a blank bus
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync    <= '1;
            r_muestra <= '1;
        end else begin
            r_sync    <= {anodo, segmentos};
            r_muestra <= r_sync;
        end
    end

    assign w_an = r_muestra[c_kw-1:8];

`ifdef DECOD7SEG_PUNTO_EN
    assign w_clave = r_muestra;
    assign w_punto = ~r_muestra[0];
`else
    // dp forced off so a dp-only change is not a new sample
    assign w_clave = r_muestra | {{(c_kw-1){1'b0}}, 1'b1};
    assign w_punto = 1'b0;
`endif

    assign w_valida   = $onehot(~w_an);
    assign w_igual    = (w_clave == r_previa);
    assign w_cnt_inc  = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_uno;
    assign w_reinicio = w_valida && ((r_estado == ESPERA) || !w_igual);
    assign w_commit   = (w_reinicio && (c_cnt_uno == c_cnt_max)) ||
                        (w_valida && w_igual && (r_estado == CUENTA) && (w_cnt_inc == c_cnt_max));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= ESPERA;
            r_cnt    <= '0;
            r_previa <= '1;
        end else begin
            r_previa <= w_clave;
            if (!w_valida) begin
                r_estado <= ESPERA;
                r_cnt    <= '0;
            end else if (w_reinicio) begin
                r_cnt    <= c_cnt_uno;
                r_estado <= w_commit ? RETENIDO : CUENTA;
            end else if (r_estado == CUENTA) begin
                r_cnt    <= w_cnt_inc;
                r_estado <= w_commit ? RETENIDO : CUENTA;
            end
        end
    end

    tabla_7seg_bcd u_tabla (
        .patron  (r_muestra[7:1]),
        .bcd     (w_dec_bcd),
        .apagado (w_dec_ap),
        .error   (w_dec_er)
    );

    assign w_sel         = ~w_an & {N_DIGITOS{w_commit}};
    assign w_mascara_sig = r_mascara | w_sel;
    assign w_completo    = w_commit && (&w_mascara_sig);

    always_comb begin
        w_cambio = 1'b0;
        for (int i = 0; i < N_DIGITOS; i++) begin
            if (w_sel[i] && ({bcd[4*i +: 4], apagado[i], error[i], punto[i]} !=
                             {w_dec_bcd, w_dec_ap, w_dec_er, w_punto}))
                w_cambio = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcd       <= '1;
            apagado   <= '1;
            error     <= '0;
            punto     <= '0;
            nuevo     <= 1'b0;
            barrido   <= 1'b0;
            r_mascara <= '0;
        end else begin
            nuevo     <= w_cambio;
            barrido   <= w_completo;
            r_mascara <= w_completo ? '0 : w_mascara_sig;
            for (int i = 0; i < N_DIGITOS; i++) begin
                if (w_sel[i]) begin
                    bcd[4*i +: 4] <= w_dec_bcd;
                    apagado[i]    <= w_dec_ap;
                    error[i]      <= w_dec_er;
                    punto[i]      <= w_punto;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decodificador_7seg_bcd.sv
// ============================================================================
//  Module   : tb_decodificador_7seg_bcd
//  Purpose  : Run-based reference model with scoreboard for decodificador_7seg_bcd.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decodificador_7seg_bcd;

    localparam int N   = 4;
    localparam int EST = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   anodo = '1;
    logic [7:0]     segmentos = 8'hFF;
    logic [4*N-1:0] bcd;
    logic [N-1:0]   apagado, error, punto;
    logic           nuevo, barrido;

    decodificador_7seg_bcd #(.N_DIGITOS(N), .ESTABLE(EST)) dut (
        .clk       (clk),
        .reset     (reset),
        .anodo     (anodo),
        .segmentos (segmentos),
        .bcd       (bcd),
        .apagado   (apagado),
        .error     (error),
        .punto     (punto),
        .nuevo     (nuevo),
        .barrido   (barrido)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int             cyc;
        logic [4*N-1:0] bcd;
        logic [N-1:0]   ap, er, pt;
        logic           nu, ba;
    } esp_t;

    esp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: what the display has shown and what the scan mask holds
    logic [4*N-1:0] m_bcd = '1;
    logic [N-1:0]   m_ap  = '1;
    logic [N-1:0]   m_er  = '0;
    logic [N-1:0]   m_pt  = '0;
    logic [N-1:0]   m_mask = '0;

    logic [6:0] tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    function automatic void decodifica(input logic [6:0] p, output logic [3:0] b,
                                       output logic ap, output logic er);
        b  = 4'hF;
        ap = (p == 7'h7F);
        er = !ap;
        for (int d = 0; d < 10; d++) begin
            if (p == tab[d]) begin
                b  = d[3:0];
                er = 1'b0;
            end
        end
    endfunction

    // A run of one bus value held for len edges, first sampled at edge e0
    function automatic void model_run(input logic [N-1:0] an, input logic [7:0] seg,
                                      input int len, input int e0);
        int         ceros = 0;
        int         idx = 0;
        logic [3:0] b;
        logic       ap, er, pt, nu, ba;
        esp_t       e;
        for (int i = 0; i < N; i++) begin
            if (!an[i]) begin
                ceros++;
                idx = i;
            end
        end
        if (ceros != 1 || len < EST) return;
        decodifica(seg[7:1], b, ap, er);
`ifdef DECOD7SEG_PUNTO_EN
        pt = ~seg[0];
`else
        pt = 1'b0;
`endif
        nu = ({m_bcd[4*idx +: 4], m_ap[idx], m_er[idx], m_pt[idx]} != {b, ap, er, pt});
        m_bcd[4*idx +: 4] = b;
        m_ap[idx] = ap;
        m_er[idx] = er;
        m_pt[idx] = pt;
        m_mask[idx] = 1'b1;
        ba = &m_mask;
        if (ba) m_mask = '0;
        if (nu || ba) begin
            e.cyc = e0 + 1 + EST;
            e.bcd = m_bcd;
            e.ap  = m_ap;
            e.er  = m_er;
            e.pt  = m_pt;
            e.nu  = nu;
            e.ba  = ba;
            q.push_back(e);
        end
    endfunction

    task automatic run(input logic [N-1:0] an, input logic [7:0] seg, input int len);
        anodo     = an;
        segmentos = seg;
        model_run(an, seg, len, cyc + 1);
        repeat (len) @(negedge clk);
    endtask

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nombre, act, exp);
        end
    endtask

    // Monitor: every nuevo/barrido pulse must match the next predicted commit
    always @(negedge clk) begin
        if (!reset) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_pulse@%0d: got no pulse expected pulse at edge %0d", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                esp_t e;
                e = q.pop_front();
                n_cmp++;
                if ({bcd, apagado, error, punto, nuevo, barrido} !==
                    {e.bcd, e.ap, e.er, e.pt, e.nu, e.ba}) begin
                    n_bad++;
                    $display("FAIL commit@%0d: got bcd=%h ap=%b er=%b pt=%b nu=%b ba=%b expected bcd=%h ap=%b er=%b pt=%b nu=%b ba=%b",
                             cyc, bcd, apagado, error, punto, nuevo, barrido,
                             e.bcd, e.ap, e.er, e.pt, e.nu, e.ba);
                end
            end else if (nuevo || barrido) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_pulse@%0d: got nuevo=%b barrido=%b expected 0 0", cyc, nuevo, barrido);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [7:0] scan_vals [4] = '{8'h03, 8'h9F, 8'h25, 8'h0D};

    initial begin
        logic [N-1:0] an;
        logic [7:0]   seg;
        int           r;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_bcd",     32'(bcd),     32'hFFFF);
        chk("reset_apagado", 32'(apagado), 32'hF);
        chk("reset_error",   32'(error),   32'h0);
        chk("reset_punto",   32'(punto),   32'h0);
        chk("reset_nuevo",   32'(nuevo),   32'h0);
        chk("reset_barrido", 32'(barrido), 32'h0);

        run(4'b1110, 8'h25, 6);
        run(4'b1111, 8'hFF, 2);
        chk("first_digit0", 32'(bcd[3:0]), 32'h2);

        for (int s = 0; s < 2; s++) begin
            for (int d = 0; d < N; d++) begin
                an = ~(4'b0001 << d);
                run(an, scan_vals[d], 4);
                run(4'b1111, 8'hFF, 2);
            end
        end
        run(4'b1111, 8'hFF, 4);
        chk("scan_bcd", 32'(bcd), 32'h3210);

        run(4'b1101, 8'h9F, 5);
        run(4'b1101, 8'h01, 2);
        run(4'b1101, 8'h9F, 5);
        run(4'b1111, 8'hFF, 4);
        chk("glitch_digit1", 32'(bcd[7:4]), 32'h1);

        run(4'b1011, 8'hFF, 4);
        run(4'b1111, 8'hFF, 4);
        chk("blank_digit2", 32'({apagado[2], bcd[11:8]}), 32'h1F);
        run(4'b1011, 8'h6D, 4);
        run(4'b1111, 8'hFF, 4);
        chk("error_digit2", 32'({error[2], apagado[2], bcd[11:8]}), 32'h2F);

        run(4'b1100, 8'h25, 10);
        run(4'b1111, 8'hFF, 2);

        for (int k = 0; k < 90; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                an = 4'($urandom);
                if ($countones(~an) < 2) an = 4'b0000;
            end else begin
                an = ~(4'b0001 << $urandom_range(0, N - 1));
            end
            r = $urandom_range(0, 9);
            if (r < 7)       seg = {tab[$urandom_range(0, 9)], 1'($urandom)};
            else if (r == 7) seg = {7'h7F, 1'($urandom)};
            else             seg = 8'($urandom);
            run(an, seg, $urandom_range(1, 5));
            run(4'b1111, 8'hFF, $urandom_range(1, 3));
        end
        run(4'b1111, 8'hFF, 6);

        // Reset with cnt=2 must abort the count and restore reset values
        anodo     = 4'b0111;
        segmentos = 8'h01;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_bcd = '1; m_ap = '1; m_er = '0; m_pt = '0; m_mask = '0;
        chk("midreset_bcd",     32'(bcd),     32'hFFFF);
        chk("midreset_apagado", 32'(apagado), 32'hF);
        chk("midreset_error",   32'(error),   32'h0);
        chk("midreset_nuevo",   32'({nuevo, barrido}), 32'h0);
        run(4'b0111, 8'h01, 5);
        run(4'b1111, 8'hFF, 8);
        chk("after_reset_digit3", 32'(bcd[15:12]), 32'h8);

        chk("queue_drained", 32'(q.size()), 32'h0);
        chk("final_bcd",     32'(bcd),     32'(m_bcd));
        chk("final_apagado", 32'(apagado), 32'(m_ap));
        chk("final_error",   32'(error),   32'(m_er));
        chk("final_punto",   32'(punto),   32'(m_pt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
